// File: rtl/wb_cmd_pkg.sv
// Shared types and register bit positions for the Wishbone command FIFO slave.
package wb_cmd_pkg;

  typedef enum logic [1:0] {
    CSR  = 2'd0,
    DPR  = 2'd1,
    CMDR = 2'd2,
    DBG  = 2'd3
  } reg_addr_t;

  localparam int CSR_E         = 7;
  localparam int CSR_IE        = 6;
  localparam int CSR_FULL      = 5;
  localparam int CSR_EMPTY     = 4;
  localparam int CSR_LEVEL_LSB = 0;

  localparam int CMDR_DON      = 7;
  localparam int CMDR_ERR      = 6;
  localparam int CMDR_OVF      = 5;
  localparam int CMDR_CODE_LSB = 0;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_READ  = 3'd1,
    CMD_WRITE = 3'd2,
    CMD_SEEK  = 3'd3,
    CMD_ERASE = 3'd4,
    CMD_STAT  = 3'd5,
    CMD_SYNC  = 3'd6,
    CMD_RESET = 3'd7
  } cmd_t;

  typedef struct packed {
    cmd_t       code;
    logic [7:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/wb_cmd_fifo_sync.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module wb_cmd_fifo_sync #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 11,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // NOTE: storage is not reset; the empty flag guarantees stale entries are never presented.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_cmd_fifo_slave.sv
// Wishbone classic slave buffering command writes for a downstream engine.
// Optional build macro WB_CMD_FIFO_DBG_EN adds an accepted-push counter at adr 3.
module wb_cmd_fifo_slave
  import wb_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  ack_o,
  output logic                  irq_o,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [2:0]            cmd_code_o,
  output logic [7:0]            cmd_data_o,
  input  logic                  rsp_valid_i,
  input  logic [7:0]            rsp_data_i,
  input  logic                  rsp_err_i
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  reg_addr_t       addr;
  logic            bus_req, bus_wr, bus_rd;
  logic            e_q, ie_q, don_q, err_q, ovf_q;
  logic [7:0]      dpr_q, rsp_q;
  cmd_t            last_cmd_q;
  logic [7:0]      rd_data;

  logic            fifo_push, fifo_pop, fifo_flush;
  logic            fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [ENTRY_W-1:0] fifo_rdata;
  fifo_entry_t     head, wr_entry;
  logic            push_acc, push_ovf, rd_clr;

  assign addr    = reg_addr_t'(adr_i);
  // Side effects fire on the request edge, which is also the edge that raises ack_o.
  assign bus_req = cyc_i & stb_i & ~ack_o;
  assign bus_wr  = bus_req & we_i;
  assign bus_rd  = bus_req & ~we_i;

  assign fifo_push  = bus_wr & (addr == CMDR) & e_q;
  assign fifo_pop   = cmd_valid_o & cmd_ready_i;
  assign fifo_flush = bus_wr & (addr == CSR) & e_q & ~dat_i[CSR_E];
  assign push_acc   = fifo_push & (~fifo_full | fifo_pop);
  assign push_ovf   = fifo_push & fifo_full & ~fifo_pop;
  assign rd_clr     = bus_rd & (addr == CMDR);

  assign wr_entry = '{code: cmd_t'(dat_i[2:0]), data: dpr_q};
  assign head     = fifo_entry_t'(fifo_rdata);

  assign cmd_valid_o = e_q & ~fifo_empty;
  assign cmd_code_o  = cmd_valid_o ? head.code : CMD_NOP;
  assign cmd_data_o  = cmd_valid_o ? head.data : 8'h00;

  wb_cmd_fifo_sync #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (wr_entry),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

`ifdef WB_CMD_FIFO_DBG_EN
  logic [7:0] dbg_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i)                         dbg_cnt_q <= 8'h00;
    else if (bus_wr && (addr == DBG))   dbg_cnt_q <= 8'h00;
    else if (push_acc)                  dbg_cnt_q <= dbg_cnt_q + 8'h01;
  end
`endif

  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    rd_data = 8'h00;
    case (addr)
      CSR: begin
        rd_data[CSR_E]     = e_q;
        rd_data[CSR_IE]    = ie_q;
        rd_data[CSR_FULL]  = fifo_full;
        rd_data[CSR_EMPTY] = fifo_empty;
        rd_data[CSR_LEVEL_LSB +: 4] = 4'(fifo_level);
      end
      DPR:  rd_data = rsp_q;
      CMDR: begin
        rd_data[CMDR_DON] = don_q;
        rd_data[CMDR_ERR] = err_q;
        rd_data[CMDR_OVF] = ovf_q;
        rd_data[CMDR_CODE_LSB +: 3] = last_cmd_q;
      end
      DBG: begin
`ifdef WB_CMD_FIFO_DBG_EN
        rd_data = dbg_cnt_q;
`endif
      end
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_o      <= 1'b0;
      dat_o      <= '0;
      irq_o      <= 1'b0;
      e_q        <= 1'b0;
      ie_q       <= 1'b0;
      don_q      <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      dpr_q      <= 8'h00;
      rsp_q      <= 8'h00;
      last_cmd_q <= CMD_NOP;
    end else begin
      ack_o <= bus_req;
      dat_o <= bus_rd ? DATA_WIDTH'(rd_data) : '0;
      if (bus_wr && (addr == CSR)) begin
        e_q  <= dat_i[CSR_E];
        ie_q <= dat_i[CSR_IE];
      end
      if (bus_wr && (addr == DPR)) dpr_q <= dat_i[7:0];
      if (push_acc)                last_cmd_q <= cmd_t'(dat_i[2:0]);
      if (rsp_valid_i)             rsp_q <= rsp_data_i;
      // An engine response in the same cycle as a read-clear keeps its flag set.
      don_q <= (don_q & ~rd_clr) | (rsp_valid_i & ~rsp_err_i);
      err_q <= (err_q & ~rd_clr) | (rsp_valid_i & rsp_err_i);
      ovf_q <= (ovf_q & ~rd_clr) | push_ovf;
      irq_o <= ie_q & (don_q | err_q | ovf_q);
    end
  end

endmodule

// File: tb/tb_wb_cmd_fifo_slave.sv
// Self-checking bench for wb_cmd_fifo_slave: directed scenarios plus random traffic vs a queue model.
module tb_wb_cmd_fifo_slave;
  import wb_cmd_pkg::*;

  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [1:0] adr_i = '0;
  logic [7:0] dat_i = '0;
  logic [7:0] dat_o;
  logic       ack_o, irq_o, cmd_valid_o;
  logic       cmd_ready_i = 1'b0;
  logic [2:0] cmd_code_o;
  logic [7:0] cmd_data_o;
  logic       rsp_valid_i = 1'b0;
  logic [7:0] rsp_data_i = '0;
  logic       rsp_err_i = 1'b0;

  wb_cmd_fifo_slave #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cyc_i       (cyc_i),
    .stb_i       (stb_i),
    .we_i        (we_i),
    .adr_i       (adr_i),
    .dat_i       (dat_i),
    .dat_o       (dat_o),
    .ack_o       (ack_o),
    .irq_o       (irq_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_code_o  (cmd_code_o),
    .cmd_data_o  (cmd_data_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_data_i  (rsp_data_i),
    .rsp_err_i   (rsp_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: command queue of {code, data} and the register/flag view.
  logic [10:0] q[$];
  bit          m_e, m_ie, m_don, m_err, m_ovf;
  logic [7:0]  m_dpr, m_rsp, m_dbg;
  logic [2:0]  m_last;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_e = 0; m_ie = 0; m_don = 0; m_err = 0; m_ovf = 0;
    m_dpr = 0; m_rsp = 0; m_dbg = 0; m_last = 0;
  endfunction

  function automatic logic [7:0] m_csr();
    return {m_e, m_ie, q.size() == DEPTH, q.size() == 0, 4'(q.size())};
  endfunction

  function automatic logic [7:0] m_cmdr();
    return {m_don, m_err, m_ovf, 2'b00, m_last};
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] adr);
    case (adr)
      2'd0:    return m_csr();
      2'd1:    return m_rsp;
      2'd2:    return m_cmdr();
`ifdef WB_CMD_FIFO_DBG_EN
      default: return m_dbg;
`else
      default: return 8'h00;
`endif
    endcase
  endfunction

  // One clock edge worth of behaviour: engine pop, optional bus access, engine response.
  function automatic void model_step(input bit is_bus, input bit we, input logic [1:0] adr,
                                     input logic [7:0] d, input bit ready, input bit rsp_v,
                                     input logic [7:0] rsp_d, input bit rsp_e);
    bit full_pre, popped;
    full_pre = (q.size() == DEPTH);
    popped   = ready && m_e && (q.size() > 0);
    if (popped) void'(q.pop_front());
    if (is_bus && we) begin
      case (adr)
        2'd0: begin
          if (m_e && !d[7]) q.delete();
          m_e = d[7]; m_ie = d[6];
        end
        2'd1: m_dpr = d;
        2'd2: if (m_e) begin
          if (!full_pre || popped) begin
            q.push_back({d[2:0], m_dpr});
            m_last = d[2:0];
            m_dbg  = m_dbg + 8'd1;
          end else m_ovf = 1;
        end
        default: m_dbg = 8'h00;
      endcase
    end
    if (is_bus && !we && adr == 2'd2) begin
      m_don = 0; m_err = 0; m_ovf = 0;
    end
    if (rsp_v) begin
      m_rsp = rsp_d;
      if (rsp_e) m_err = 1; else m_don = 1;
    end
  endfunction

  task automatic check_state(input string tag);
    bit v;
    v = m_e && (q.size() > 0);
    check({tag, "_valid"}, cmd_valid_o, v);
    check({tag, "_code"}, cmd_code_o, v ? q[0][10:8] : 3'd0);
    check({tag, "_data"}, cmd_data_o, v ? q[0][7:0] : 8'h00);
    check({tag, "_irq"}, irq_o, m_ie & (m_don | m_err | m_ovf));
  endtask

  // Full bus transaction, started and finished 1 time unit after a rising edge.
  task automatic bus_op(input bit we, input logic [1:0] adr, input logic [7:0] d,
                        input bit ready, input bit rsp_v, input logic [7:0] rsp_d,
                        input bit rsp_e, input string tag, output logic [7:0] got);
    logic [7:0] exp_rd;
    int waited;
    exp_rd = m_read(adr);
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = d;
    cmd_ready_i = ready; rsp_valid_i = rsp_v; rsp_data_i = rsp_d; rsp_err_i = rsp_e;
    @(posedge clk_i); #1;
    cmd_ready_i = 0; rsp_valid_i = 0;
    waited = 0;
    while (!ack_o && waited < 8) begin
      @(posedge clk_i); #1;
      waited++;
    end
    check({tag, "_ack"}, ack_o, 1'b1);
    check({tag, "_lat"}, 8'(waited), 8'd0);
    got = dat_o;
    cyc_i = 0; stb_i = 0; we_i = 0;
    model_step(1, we, adr, d, ready, rsp_v, rsp_d, rsp_e);
    if (!we) check({tag, "_rd"}, got, exp_rd);
    @(posedge clk_i); #1;
    check({tag, "_ackdrop"}, ack_o, 1'b0);
    check_state(tag);
  endtask

  task automatic wr(input logic [1:0] adr, input logic [7:0] d, input string tag);
    logic [7:0] unused;
    bus_op(1, adr, d, 0, 0, 8'h00, 0, tag, unused);
  endtask

  task automatic rd(input logic [1:0] adr, input string tag, output logic [7:0] got);
    bus_op(0, adr, 8'h00, 0, 0, 8'h00, 0, tag, got);
  endtask

  task automatic pulse(input bit ready, input bit rsp_v, input logic [7:0] rsp_d,
                       input bit rsp_e, input string tag);
    cmd_ready_i = ready; rsp_valid_i = rsp_v; rsp_data_i = rsp_d; rsp_err_i = rsp_e;
    @(posedge clk_i); #1;
    cmd_ready_i = 0; rsp_valid_i = 0;
    model_step(0, 0, 2'd0, 8'h00, ready, rsp_v, rsp_d, rsp_e);
    @(posedge clk_i); #1;
    check_state(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    model_reset();

    // 1: reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", ack_o, 1'b0);
    check("rst_dat", dat_o, 8'h00);
    check("rst_irq", irq_o, 1'b0);
    check("rst_valid", cmd_valid_o, 1'b0);
    rst_i = 1;
    rd(2'd0, "t1_csr", v);
    check("t1_csr_const", v, 8'h10);

    // 2: single command
    wr(2'd0, 8'hC0, "t2_csr_wr");
    wr(2'd1, 8'hA5, "t2_dpr_wr");
    wr(2'd2, 8'h02, "t2_push");
    check("t2_valid", cmd_valid_o, 1'b1);
    check("t2_code", cmd_code_o, 3'd2);
    check("t2_data", cmd_data_o, 8'hA5);
    rd(2'd0, "t2_csr", v);
    check("t2_csr_const", v, 8'hC1);

    // 3: fill and overflow
    wr(2'd2, 8'h03, "t3_push2");
    wr(2'd2, 8'h04, "t3_push3");
    wr(2'd2, 8'h05, "t3_push4");
    wr(2'd2, 8'h05, "t3_push5");
    check("t3_irq_set", irq_o, 1'b1);
    rd(2'd0, "t3_csr", v);
    check("t3_csr_const", v, 8'hE4);
    rd(2'd2, "t3_cmdr1", v);
    check("t3_cmdr1_const", v, 8'h25);
    rd(2'd2, "t3_cmdr2", v);
    check("t3_cmdr2_const", v, 8'h05);
    check("t3_irq_clr", irq_o, 1'b0);

    // 4: push while full with a simultaneous pop
    bus_op(1, 2'd2, 8'h06, 1, 0, 8'h00, 0, "t4_push_pop", v);
    check("t4_head_code", cmd_code_o, 3'd3);
    rd(2'd0, "t4_csr", v);
    check("t4_csr_const", v, 8'hE4);
    rd(2'd2, "t4_cmdr", v);
    check("t4_cmdr_const", v, 8'h06);

    // 5: error response, then response colliding with read-clear
    pulse(0, 1, 8'h3C, 1, "t5_rsp");
    check("t5_irq", irq_o, 1'b1);
    rd(2'd1, "t5_dpr", v);
    check("t5_dpr_const", v, 8'h3C);
    rd(2'd2, "t5_cmdr", v);
    check("t5_cmdr_const", v, 8'h46);
    bus_op(0, 2'd2, 8'h00, 0, 1, 8'h3C, 1, "t5_collide", v);
    check("t5_collide_const", v, 8'h06);
    rd(2'd2, "t5_after", v);
    check("t5_err_kept", v[6], 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      case ($urandom_range(0, 8))
        0: begin
          d[7] = ($urandom_range(0, 7) != 0);
          wr(2'd0, d, "r_csr_wr");
        end
        1: wr(2'd1, d, "r_dpr_wr");
        2, 3: bus_op(1, 2'd2, d, 1'($urandom_range(0, 1)), 0, 8'h00, 0, "r_push", v);
        4: rd(2'd0, "r_csr", v);
        5: rd(2'd2, "r_cmdr", v);
        6: rd(2'd1, "r_dpr", v);
        7: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), "r_pulse");
        default: begin
          if ($urandom_range(0, 3) == 0) wr(2'd3, d, "r_dbg_wr");
          else rd(2'd3, "r_dbg", v);
        end
      endcase
    end

    // 6: reset in the middle of a held request
    wr(2'd0, 8'hC0, "t6_en");
    wr(2'd2, 8'h01, "t6_push");
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 2'd0;
    rst_i = 0;
    @(posedge clk_i); #1;
    check("t6_ack_in_rst1", ack_o, 1'b0);
    @(posedge clk_i); #1;
    check("t6_ack_in_rst2", ack_o, 1'b0);
    model_reset();
    rst_i = 1;
    @(posedge clk_i); #1;
    check("t6_ack_after", ack_o, 1'b1);
    check("t6_csr_after", dat_o, 8'h10);
    cyc_i = 0; stb_i = 0;
    @(posedge clk_i); #1;
    check("t6_ack_drop", ack_o, 1'b0);
    check_state("t6_state");
    rd(2'd0, "t6_csr", v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
